// File: rtl/utils_shifter_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROL/ROR) with tag sideband and flush.
// The log2 shift levels are spread evenly over PIPE_STAGES registered stages.
module utils_shifter_pipe #(
   parameter int DATA_WIDTH  = 32,
   parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH),
   parameter int PIPE_STAGES = 2,
   parameter int TAG_WIDTH   = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic                   flush_i,
   input  logic                   in_valid_i,
   output logic                   in_ready_o,
   input  logic [2:0]             in_mode_i,
   input  logic [DATA_WIDTH-1:0]  in_src_i,
   input  logic [SHAMT_WIDTH-1:0] in_shamt_i,
   input  logic [TAG_WIDTH-1:0]   in_tag_i,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic [DATA_WIDTH-1:0]  out_res_o,
   output logic [TAG_WIDTH-1:0]   out_tag_o
);

   localparam logic [2:0] MODE_SLL = 3'd0;
   localparam logic [2:0] MODE_SRL = 3'd1;
   localparam logic [2:0] MODE_SRA = 3'd2;
   localparam logic [2:0] MODE_ROL = 3'd3;
   localparam logic [2:0] MODE_ROR = 3'd4;

   // One shift level by n bits. Composing levels stays correct for SRA because the
   // sign bit is preserved in the msb by every earlier arithmetic level.
   function automatic logic [DATA_WIDTH-1:0] shift_level(input logic [DATA_WIDTH-1:0] d,
                                                         input logic [2:0] m, input int n);
      logic [DATA_WIDTH-1:0] r;
      case (m)
         MODE_SLL: r = d << n;
         MODE_SRL: r = d >> n;
         MODE_SRA: r = $signed(d) >>> n;
         MODE_ROL: r = (d << n) | (d >> (DATA_WIDTH - n));
         MODE_ROR: r = (d >> n) | (d << (DATA_WIDTH - n));
         default:  r = '0;
      endcase
      return r;
   endfunction

   logic [PIPE_STAGES-1:0]  vld;
   logic [PIPE_STAGES:0]    ld;
   logic [DATA_WIDTH-1:0]   dat_s  [PIPE_STAGES];
   logic [2:0]              mode_s [PIPE_STAGES];
   logic [SHAMT_WIDTH-1:0]  sh_s   [PIPE_STAGES];
   logic [TAG_WIDTH-1:0]    tag_s  [PIPE_STAGES];

   // Handshake: a transfer happens on a rising edge where valid & ready are both high;
   // valid never depends on ready, and ld[k] (stage k may load) ripples back
   // combinationally from out_ready_i so bubbles collapse.
   always_comb begin
      ld = '0;
      ld[PIPE_STAGES] = out_ready_i;
      for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
         ld[k] = ~vld[k] | ld[k+1];
      end
   end

   for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
      logic                   r_vld;
      logic [DATA_WIDTH-1:0]  r_dat;
      logic [2:0]             r_mode;
      logic [SHAMT_WIDTH-1:0] r_sh;
      logic [TAG_WIDTH-1:0]   r_tag;
      logic                   v_in;
      logic [DATA_WIDTH-1:0]  d_in;
      logic [DATA_WIDTH-1:0]  d_nxt;
      logic [2:0]             m_in;
      logic [SHAMT_WIDTH-1:0] sh_in;
      logic [TAG_WIDTH-1:0]   t_in;

      if (k == 0) begin : g_head
         // Reserved modes are zeroed on entry; every later level then keeps them at zero.
         assign v_in  = in_valid_i;
         assign d_in  = (in_mode_i > MODE_ROR) ? '0 : in_src_i;
         assign m_in  = in_mode_i;
         assign sh_in = in_shamt_i;
         assign t_in  = in_tag_i;
      end else begin : g_body
         assign v_in  = vld[k-1];
         assign d_in  = dat_s[k-1];
         assign m_in  = mode_s[k-1];
         assign sh_in = sh_s[k-1];
         assign t_in  = tag_s[k-1];
      end

      always_comb begin
         d_nxt = d_in;
         for (int i = 0; i < SHAMT_WIDTH; i++) begin
            if (((i * PIPE_STAGES) / SHAMT_WIDTH) == k && sh_in[i]) begin
               d_nxt = shift_level(d_nxt, m_in, 1 << i);
            end
         end
      end

      always_ff @(posedge clk_i) begin
         if (!rst_n_i) begin
            r_vld  <= 1'b0;
            r_dat  <= '0;
            r_mode <= '0;
            r_sh   <= '0;
            r_tag  <= '0;
         end else begin
            if (flush_i) begin
               r_vld <= 1'b0;
            end else if (ld[k]) begin
               r_vld <= v_in;
            end
            if (!flush_i && ld[k] && v_in) begin
               r_dat  <= d_nxt;
               r_mode <= m_in;
               r_sh   <= sh_in;
               r_tag  <= t_in;
            end
         end
      end

      assign vld[k]    = r_vld;
      assign dat_s[k]  = r_dat;
      assign mode_s[k] = r_mode;
      assign sh_s[k]   = r_sh;
      assign tag_s[k]  = r_tag;
   end

   // The last stage's mode and shamt copies have no consumer.
   logic unused_tail;
   assign unused_tail = ^{mode_s[PIPE_STAGES-1], sh_s[PIPE_STAGES-1]};

   assign in_ready_o  = ld[0];
   assign out_valid_o = vld[PIPE_STAGES-1];
   assign out_res_o   = dat_s[PIPE_STAGES-1];
   assign out_tag_o   = tag_s[PIPE_STAGES-1];

endmodule
